dcache_writeback_unit: RTL and testbench

Drains one evicted data-cache block to memory. Sits between the data cache controller, which issues the eviction request, and the memory store channel. It reads each word of the victim block from the cache data array, issues one memory store per word under a valid/ready handshake, then rewrites the block status with the dirty bit cleared. A block that is invalid or clean completes with no memory traffic.

---
 rtl/dcache_writeback_unit.sv | 161 ++++++++++++++++
 tb/tb_dcache_writeback_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dcache_writeback_unit.sv
// dcache_writeback_unit: drains one evicted data-cache block to memory.
// Each word of the victim block is read from the data array, stored to
// memory one word at a time, and the status is then rewritten clean.
// Blocks that are invalid or clean finish with no memory traffic.
//
// Store handshake: a store transfers on a cycle where mem_store_o and
// mem_ready_i are both 1. While mem_store_o=1 and mem_ready_i=0, the
// outputs mem_address_o, mem_data_o and mem_last_o hold their values.
package dcache_writeback_pkg;
  typedef struct packed {
    logic valid;
    logic dirty;
  } status_packet_t;

  typedef struct packed {
    logic valid;
    logic dirty;
    logic tag;
    logic data;
  } data_enable_t;
endpackage

module dcache_writeback_unit
  import dcache_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int INDEX_BITS  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          evict_i,
  input  status_packet_t                evict_status_i,
  input  logic [ADDR_WIDTH-1:0]         evict_address_i,
  input  logic [INDEX_BITS-1:0]         evict_index_i,
  input  logic                          evict_invalidate_i,
  output logic                          evict_ready_o,
  output data_enable_t                  cache_enable_o,
  output logic                          cache_write_o,
  output logic [INDEX_BITS-1:0]         cache_index_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] cache_word_o,
  output status_packet_t                cache_status_o,
  input  logic [DATA_WIDTH-1:0]         cache_data_i,
  output logic                          mem_store_o,
  output logic [ADDR_WIDTH-1:0]         mem_address_o,
  output logic [DATA_WIDTH-1:0]         mem_data_o,
  output logic                          mem_last_o,
  input  logic                          mem_ready_i,
  output logic                          done_o
);

  localparam int WORD_BYTES = DATA_WIDTH / 8;
  localparam int OFF_BITS   = $clog2(BLOCK_WORDS * WORD_BYTES);
  localparam int CNT_BITS   = $clog2(BLOCK_WORDS);
  localparam logic [CNT_BITS-1:0] LAST_WORD = CNT_BITS'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    CLEAN = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   blk_addr;
  logic [INDEX_BITS-1:0]   index_q;
  logic                    inv_q;
  logic                    need_wb;
  logic [CNT_BITS-1:0]     count;
  logic [DATA_WIDTH-1:0]   buffer;

  // State register plus captured request fields, word counter and data buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      blk_addr <= '0;
      index_q  <= '0;
      inv_q    <= 1'b0;
      need_wb  <= 1'b0;
      count    <= '0;
      buffer   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (evict_i) begin
            blk_addr <= {evict_address_i[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
            index_q  <= evict_index_i;
            inv_q    <= evict_invalidate_i;
            need_wb  <= evict_status_i.valid & evict_status_i.dirty;
            count    <= '0;
          end
        end
        LATCH: buffer <= cache_data_i;
        SEND: begin
          if (mem_ready_i && (count != LAST_WORD)) begin
            count <= count + CNT_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode; every output defaults to 0.
  always_comb begin
    state_next     = state;
    evict_ready_o  = 1'b0;
    cache_enable_o = '0;
    cache_write_o  = 1'b0;
    cache_index_o  = '0;
    cache_word_o   = '0;
    cache_status_o = '0;
    mem_store_o    = 1'b0;
    mem_address_o  = '0;
    mem_data_o     = '0;
    mem_last_o     = 1'b0;
    done_o         = 1'b0;
    case (state)
      IDLE: begin
        evict_ready_o = 1'b1;
        if (evict_i) begin
          state_next = (evict_status_i.valid & evict_status_i.dirty) ? FETCH : CLEAN;
        end
      end
      FETCH: begin
        cache_enable_o.data = 1'b1;
        cache_index_o       = index_q;
        cache_word_o        = count;
        state_next          = LATCH;
      end
      LATCH: state_next = SEND;
      SEND: begin
        mem_store_o   = 1'b1;
        mem_address_o = blk_addr + ADDR_WIDTH'(count) * ADDR_WIDTH'(WORD_BYTES);
        mem_data_o    = buffer;
        mem_last_o    = (count == LAST_WORD);
        if (mem_ready_i) begin
          state_next = (count == LAST_WORD) ? CLEAN : FETCH;
        end
      end
      CLEAN: begin
        done_o     = 1'b1;
        state_next = IDLE;
        if (need_wb) begin
          cache_enable_o.valid = 1'b1;
          cache_enable_o.dirty = 1'b1;
          cache_write_o        = 1'b1;
          cache_index_o        = index_q;
          cache_status_o.valid = ~inv_q;
          cache_status_o.dirty = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_writeback_unit.sv
// Bench for dcache_writeback_unit: directed scenarios followed by random
// evictions, each checked against a transaction-level model of the stores,
// completion latency and status rewrite.
module tb_dcache_writeback_unit;
  import dcache_writeback_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int IB = 8;
  localparam int SW = AW + DW + 1;

  logic                  clk = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  evict_i = 1'b0;
  status_packet_t        evict_status_i = '0;
  logic [AW-1:0]         evict_address_i = '0;
  logic [IB-1:0]         evict_index_i = '0;
  logic                  evict_invalidate_i = 1'b0;
  logic                  evict_ready_o;
  data_enable_t          cache_enable_o;
  logic                  cache_write_o;
  logic [IB-1:0]         cache_index_o;
  logic [$clog2(BW)-1:0] cache_word_o;
  status_packet_t        cache_status_o;
  logic [DW-1:0]         cache_data_i = '0;
  logic                  mem_store_o;
  logic [AW-1:0]         mem_address_o;
  logic [DW-1:0]         mem_data_o;
  logic                  mem_last_o;
  logic                  mem_ready_i = 1'b1;
  logic                  done_o;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] wdata [BW];
  logic [SW-1:0] exp_q [$];

  dcache_writeback_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW), .INDEX_BITS(IB)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .evict_i(evict_i), .evict_status_i(evict_status_i),
    .evict_address_i(evict_address_i), .evict_index_i(evict_index_i),
    .evict_invalidate_i(evict_invalidate_i), .evict_ready_o(evict_ready_o),
    .cache_enable_o(cache_enable_o), .cache_write_o(cache_write_o),
    .cache_index_o(cache_index_o), .cache_word_o(cache_word_o),
    .cache_status_o(cache_status_o), .cache_data_i(cache_data_i),
    .mem_store_o(mem_store_o), .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
    .mem_last_o(mem_last_o), .mem_ready_i(mem_ready_i), .done_o(done_o)
  );

  // Clock.
  always #5 clk = ~clk;

  // Cache data array model: read data appears one cycle after the read enable.
  always @(posedge clk) begin
    if (cache_enable_o.data && !cache_write_o) cache_data_i <= wdata[cache_word_o];
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one eviction at the current negedge (unit idle) and follow it to completion.
  task automatic run_evict(input logic [AW-1:0] addr, input logic valid, input logic dirty,
                           input logic [IB-1:0] idx, input logic inv,
                           input int stall_word, input int stall_len,
                           input bit hold, input bit fixed_data);
    logic          need = valid & dirty;
    logic [AW-1:0] base = {addr[AW-1:4], 4'h0};
    int            exp_done = need ? (1 + 3 * BW + stall_len) : 1;
    int            cyc = 0;
    int            stalls = 0;
    int            stores = 0;
    bit            seen = 0;
    exp_q.delete();
    for (int k = 0; k < BW; k++) begin
      wdata[k] = fixed_data ? DW'(32'hA0 + k) : DW'($urandom);
      if (need) exp_q.push_back({base + AW'(k * (DW / 8)), wdata[k], (k == BW - 1)});
    end
    chk("ready_before", 96'(evict_ready_o), 96'(1));
    evict_address_i    = addr;
    evict_status_i     = {valid, dirty};
    evict_index_i      = idx;
    evict_invalidate_i = inv;
    evict_i            = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) evict_i = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mem_ready_i = 1'b1;
      if (mem_store_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_store", 96'(mem_store_o), 96'(0));
        end else begin
          chk("store_word", 96'({mem_address_o, mem_data_o, mem_last_o}), 96'(exp_q[0]));
          if (stores == stall_word && stalls < stall_len) begin
            mem_ready_i = 1'b0;
            stalls++;
          end else begin
            void'(exp_q.pop_front());
            stores++;
          end
        end
      end
      if (cache_enable_o.data) begin
        chk("read_enable", 96'(cache_enable_o), 96'(need ? 4'b0001 : 4'b0000));
        chk("read_index", 96'(cache_index_o), 96'(idx));
        chk("read_write", 96'(cache_write_o), 96'(0));
      end
      if (done_o) begin
        seen = 1;
        chk("done_cycle", 96'(cyc), 96'(exp_done));
        chk("clean_enable", 96'(cache_enable_o), 96'(need ? 4'b1100 : 4'b0000));
        chk("clean_write", 96'(cache_write_o), 96'(need));
        chk("clean_index", 96'(cache_index_o), 96'(need ? idx : '0));
        chk("clean_status", 96'(cache_status_o), 96'(need ? {~inv, 1'b0} : 2'b00));
        chk("stores_left", 96'(exp_q.size()), 96'(0));
      end else begin
        chk("busy_not_ready", 96'(evict_ready_o), 96'(0));
      end
    end
    if (!seen) chk("done_timeout", 96'(done_o), 96'(1));
    mem_ready_i = 1'b1;
    @(negedge clk);
    chk("ready_after", 96'(evict_ready_o), 96'(1));
    chk("no_store_after", 96'(mem_store_o), 96'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 96'(evict_ready_o), 96'(1));
    chk({tag, "_done"}, 96'(done_o), 96'(0));
    chk({tag, "_store"}, 96'(mem_store_o), 96'(0));
    chk({tag, "_last"}, 96'(mem_last_o), 96'(0));
    chk({tag, "_addr"}, 96'(mem_address_o), 96'(0));
    chk({tag, "_data"}, 96'(mem_data_o), 96'(0));
    chk({tag, "_enable"}, 96'(cache_enable_o), 96'(0));
    chk({tag, "_write"}, 96'(cache_write_o), 96'(0));
    chk({tag, "_index"}, 96'(cache_index_o), 96'(0));
    chk({tag, "_word"}, 96'(cache_word_o), 96'(0));
    chk({tag, "_status"}, 96'(cache_status_o), 96'(0));
  endtask

  initial begin
    bit found = 0;
    for (int k = 0; k < BW; k++) wdata[k] = '0;
    // Reset values while reset is held.
    #2;
    chk_reset_outputs("por");
    @(negedge clk);
    rst_i = 1'b0;

    // Dirty block, ready always 1.
    run_evict(32'h0000_1234, 1'b1, 1'b1, 8'h12, 1'b0, 0, 0, 1'b0, 1'b1);
    // Clean block, then invalid block.
    run_evict(32'h0000_5678, 1'b1, 1'b0, 8'h34, 1'b0, 0, 0, 1'b0, 1'b0);
    run_evict(32'h0000_9ABC, 1'b0, 1'b1, 8'h56, 1'b0, 0, 0, 1'b0, 1'b0);
    // Backpressure: five stall cycles on word 2.
    run_evict(32'h0000_2000, 1'b1, 1'b1, 8'h20, 1'b0, 2, 5, 1'b0, 1'b0);
    // Invalidate on a dirty block.
    run_evict(32'hDEAD_BEE0, 1'b1, 1'b1, 8'hEE, 1'b1, 0, 0, 1'b0, 1'b0);

    // Reset while word 1 is being offered.
    for (int k = 0; k < BW; k++) wdata[k] = DW'($urandom);
    evict_address_i    = 32'h0000_1234;
    evict_status_i     = 2'b11;
    evict_index_i      = 8'h12;
    evict_invalidate_i = 1'b0;
    evict_i            = 1'b1;
    @(posedge clk);
    #1;
    evict_i = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (mem_store_o && mem_address_o == 32'h0000_1234) begin
        found = 1;
        mem_ready_i = 1'b0;
      end
    end
    if (!found) chk("reset_reach_word1", 96'(mem_store_o), 96'(1));
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    chk("rst_no_done", 96'(done_o), 96'(0));
    rst_i = 1'b0;
    mem_ready_i = 1'b1;
    @(negedge clk);
    chk("post_rst_no_done", 96'(done_o), 96'(0));
    run_evict(32'h0000_1234, 1'b1, 1'b1, 8'h12, 1'b0, 0, 0, 1'b0, 1'b1);

    // Busy: request held high through a transaction, then new inputs in the idle cycle.
    run_evict(32'h0000_4440, 1'b1, 1'b1, 8'h44, 1'b0, 1, 2, 1'b1, 1'b0);
    run_evict(32'h0000_7770, 1'b1, 1'b1, 8'h77, 1'b1, 0, 0, 1'b0, 1'b0);

    // Random evictions.
    for (int t = 0; t < 12; t++) begin
      run_evict(AW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                IB'($urandom), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, BW - 1)), int'($urandom_range(0, 3)),
                1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
